// File: rtl/sobel_window_fetch_if.sv
// sobel_window_fetch_if: RAM read bus plus 3x3 window stream of the Sobel window fetcher
interface sobel_window_fetch_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 1024,
   parameter int PIX_W  = 8
);
   logic [ADDR_W-1:0]  mem_address;
   logic               mem_chipselect;
   logic               mem_clken;
   logic [DATA_W-1:0]  mem_readdata;
   logic               win_valid;
   logic               win_ready;
   logic [9*PIX_W-1:0] win_data;
   logic [ADDR_W-1:0]  win_row;
   logic [6:0]         win_col;
   logic               win_last;
   modport master (
      output mem_address, mem_chipselect, mem_clken, win_valid, win_data, win_row, win_col, win_last,
      input  mem_readdata, win_ready
   );
   modport slave (
      input  mem_address, mem_chipselect, mem_clken, win_valid, win_data, win_row, win_col, win_last,
      output mem_readdata, win_ready
   );
endinterface

// File: rtl/sobel_window_fetch.sv
// sobel_window_fetch: reads image rows into a rolling 3-row buffer and streams every interior 3x3 window
module sobel_window_fetch #(
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 1024,
   parameter int PIX_W    = 8,
   parameter int NUM_ROWS = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic busy,
   output logic done,
   sobel_window_fetch_if.master bus
);
   localparam int PPR = DATA_W / PIX_W;
   localparam logic [6:0] LAST_COL = 7'(PPR - 2);
   localparam logic [ADDR_W:0] NR = (ADDR_W + 1)'(NUM_ROWS);
   typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, EMIT} state_t;
   state_t state;
   logic [2:0][DATA_W-1:0] rb;
   logic [ADDR_W:0] row_ptr, row_m2;
   logic [1:0] loaded;
   logic [6:0] col;
   logic cs, valid;
   logic [9*PIX_W-1:0] wd;
   // row_ptr already points past the newest row, so the window centre is two behind it
   assign row_m2 = row_ptr - (ADDR_W + 1)'(2);
   assign bus.mem_address = row_ptr[ADDR_W-1:0];
   assign bus.mem_chipselect = cs;
   assign bus.mem_clken = cs;
   assign bus.win_valid = valid;
   assign bus.win_row = valid ? row_m2[ADDR_W-1:0] : '0;
   assign bus.win_col = valid ? col : '0;
   assign bus.win_last = valid && col == LAST_COL && row_ptr == NR;
   assign bus.win_data = wd;
   always_comb begin
      wd = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            wd[PIX_W*(3*i+j) +: PIX_W] = rb[i][PIX_W*(int'(col)+j-1) +: PIX_W];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy <= 1'b0;
         done <= 1'b0;
         cs <= 1'b0;
         valid <= 1'b0;
         rb <= '0;
         row_ptr <= '0;
         loaded <= '0;
         col <= 7'd1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE:
               if (start) begin
                  row_ptr <= '0;
                  loaded <= '0;
                  busy <= 1'b1;
                  cs <= 1'b1;
                  state <= RD_REQ;
               end
            RD_REQ: begin
               cs <= 1'b0;
               state <= RD_WAIT;
            end
            RD_WAIT: begin
               rb <= {bus.mem_readdata, rb[2], rb[1]};
               row_ptr <= row_ptr + (ADDR_W + 1)'(1);
               loaded <= loaded == 2'd3 ? 2'd3 : loaded + 2'd1;
               if (loaded < 2'd2) begin
                  cs <= 1'b1;
                  state <= RD_REQ;
               end else begin
                  col <= 7'd1;
                  valid <= 1'b1;
                  state <= EMIT;
               end
            end
            EMIT:
               if (bus.win_ready) begin
                  if (col < LAST_COL) col <= col + 7'd1;
                  else begin
                     col <= 7'd1;
                     valid <= 1'b0;
                     if (row_ptr < NR) begin
                        cs <= 1'b1;
                        state <= RD_REQ;
                     end else begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        state <= IDLE;
                     end
                  end
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sobel_window_fetch.sv
// tb_sobel_window_fetch: directed passes over a (r+c) test image with a behavioural RAM and stream monitor
module tb_sobel_window_fetch;
   localparam int ADDR_W = 6;
   localparam int DATA_W = 1024;
   localparam int PIX_W = 8;
   logic clk, reset, start, busy, done;
   logic rnd;
   logic [DATA_W-1:0] rdata;
   sobel_window_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PIX_W(PIX_W)) bus ();
   sobel_window_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PIX_W(PIX_W), .NUM_ROWS(64)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .bus(bus)
   );
   int checks = 0, passes = 0;
   int cyc = 0;
   int exp_r, exp_c, nwin, nlast, last_r, last_c, last_cyc, done_cyc;
   int win_errs, stall_errs, stalls, done_cnt, cs_cyc;
   int addr_log[$];
   logic [71:0] win_mem [64*128];
   bit pv, prev_busy;
   logic [71:0] sd;
   logic [5:0] sr;
   logic [6:0] sc;
   logic sl;
   typedef struct {int r; int c; logic [7:0] p0; logic [7:0] p4; logic [7:0] p8;} vec_t;
   vec_t tbl[7];

   function automatic logic [DATA_W-1:0] row_word(int a);
      logic [DATA_W-1:0] w;
      for (int c = 0; c < 128; c++) w[8*c +: 8] = 8'(a + c);
      return w;
   endfunction

   function automatic logic [71:0] exp_win(int r, int c);
      logic [71:0] w;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) w[8*(3*i+j) +: 8] = 8'(r - 1 + i + c - 1 + j);
      return w;
   endfunction

   task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
   endtask

   task automatic wait_done(input int maxc, output bit ok);
      ok = 0;
      for (int k = 0; k < maxc; k++) begin
         @(negedge clk);
         if (done) begin ok = 1; break; end
      end
      #1;
   endtask

   task automatic wait_win(input int r, input int c, input int maxc, output bit ok);
      ok = 0;
      for (int k = 0; k < maxc; k++) begin
         @(negedge clk);
         if (bus.win_valid && int'(bus.win_row) == r && (c < 0 || int'(bus.win_col) == c)) begin ok = 1; break; end
      end
   endtask

   task automatic pulse_start();
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   function automatic int addr_errs();
      int e = 0;
      foreach (addr_log[i]) if (addr_log[i] != i) e++;
      return e;
   endfunction

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.mem_chipselect && bus.mem_clken) rdata <= row_word(int'(bus.mem_address));
   end
   assign bus.mem_readdata = rdata;

   initial begin
      bus.win_ready = 1;
      forever begin
         @(posedge clk);
         #1;
         bus.win_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (busy && !prev_busy) begin
         exp_r = 1; exp_c = 1; nwin = 0; nlast = 0; win_errs = 0; stall_errs = 0;
         stalls = 0; done_cnt = 0; cs_cyc = 0; addr_log.delete();
      end
      prev_busy = busy;
      if (bus.mem_chipselect) begin cs_cyc++; addr_log.push_back(int'(bus.mem_address)); end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (pv && (!bus.win_valid || bus.win_data !== sd || bus.win_row !== sr || bus.win_col !== sc || bus.win_last !== sl))
         stall_errs++;
      pv = bus.win_valid && !bus.win_ready;
      if (pv) stalls++;
      sd = bus.win_data; sr = bus.win_row; sc = bus.win_col; sl = bus.win_last;
      if (bus.win_valid && bus.win_ready) begin
         if (int'(bus.win_row) != exp_r || int'(bus.win_col) != exp_c || bus.win_data !== exp_win(exp_r, exp_c)
             || bus.win_last !== (exp_r == 62 && exp_c == 126))
            win_errs++;
         win_mem[int'(bus.win_row)*128 + int'(bus.win_col)] = bus.win_data;
         nwin++;
         if (bus.win_last) begin nlast++; last_r = int'(bus.win_row); last_c = int'(bus.win_col); last_cyc = cyc; end
         if (exp_c == 126) begin exp_c = 1; exp_r++; end
         else exp_c++;
      end
   end

   initial begin
      bit ok;
      logic [71:0] w;
      tbl[0] = '{1, 1, 8'h00, 8'h02, 8'h04};
      tbl[1] = '{2, 1, 8'h01, 8'h03, 8'h05};
      tbl[2] = '{1, 126, 8'h7D, 8'h7F, 8'h81};
      tbl[3] = '{10, 50, 8'h3A, 8'h3C, 8'h3E};
      tbl[4] = '{40, 126, 8'hA4, 8'hA6, 8'hA8};
      tbl[5] = '{62, 1, 8'h3D, 8'h3F, 8'h41};
      tbl[6] = '{62, 126, 8'hBA, 8'hBC, 8'hBE};
      reset = 1; start = 0; rnd = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", bus.win_valid, 0);
      chk("rst_cs", bus.mem_chipselect, 0);
      chk("rst_clken", bus.mem_clken, 0);
      chk("rst_addr", bus.mem_address, 0);
      chk("rst_data", bus.win_data, 0);
      chk("rst_row", bus.win_row, 0);
      chk("rst_col", bus.win_col, 0);
      chk("rst_last", bus.win_last, 0);
      reset = 0;
      @(negedge clk);
      pulse_start();
      chk("p1_busy", busy, 1);
      chk("p1_cs", bus.mem_chipselect, 1);
      chk("p1_addr0", bus.mem_address, 0);
      repeat (20) @(negedge clk);
      pulse_start();
      wait_done(20000, ok);
      chk("p1_done", ok, 1);
      chk("p1_busy_low", busy, 0);
      chk("p1_windows", nwin, 7812);
      chk("p1_last_cnt", nlast, 1);
      chk("p1_last_row", last_r, 62);
      chk("p1_last_col", last_c, 126);
      chk("p1_done_gap", done_cyc - last_cyc, 1);
      chk("p1_win_errs", win_errs, 0);
      chk("p1_reads", addr_log.size(), 64);
      chk("p1_addr_order", addr_errs(), 0);
      chk("p1_cs_cycles", cs_cyc, 64);
      for (int k = 0; k < 7; k++) begin
         w = win_mem[tbl[k].r*128 + tbl[k].c];
         chk($sformatf("tbl%0d_p0", k), w[7:0], tbl[k].p0);
         chk($sformatf("tbl%0d_p4", k), w[39:32], tbl[k].p4);
         chk($sformatf("tbl%0d_p8", k), w[71:64], tbl[k].p8);
      end
      pulse_start();
      chk("p2_start_on_done", busy, 1);
      wait_win(1, 126, 2000, ok);
      chk("wrap_reach", ok, 1);
      @(negedge clk);
      chk("wrap_req_cs", bus.mem_chipselect, 1);
      chk("wrap_req_addr", bus.mem_address, 3);
      chk("wrap_req_valid", bus.win_valid, 0);
      @(negedge clk);
      chk("wrap_wait_cs", bus.mem_chipselect, 0);
      chk("wrap_wait_valid", bus.win_valid, 0);
      @(negedge clk);
      chk("wrap_valid", bus.win_valid, 1);
      chk("wrap_row", bus.win_row, 2);
      chk("wrap_col", bus.win_col, 1);
      chk("wrap_p0", bus.win_data[7:0], 8'h01);
      chk("wrap_p8", bus.win_data[71:64], 8'h05);
      rnd = 1;
      wait_done(40000, ok);
      rnd = 0;
      chk("p2_done", ok, 1);
      chk("p2_windows", nwin, 7812);
      chk("p2_win_errs", win_errs, 0);
      chk("p2_stall_errs", stall_errs, 0);
      chk("p2_stalls_seen", stalls > 0, 1);
      chk("p2_done_cnt", done_cnt, 1);
      chk("p2_addr_order", addr_errs(), 0);
      @(negedge clk);
      pulse_start();
      wait_win(10, -1, 3000, ok);
      chk("p3_row10", ok, 1);
      reset = 1;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_valid", bus.win_valid, 0);
      chk("abort_cs", bus.mem_chipselect, 0);
      chk("abort_data", bus.win_data, 0);
      chk("abort_row", bus.win_row, 0);
      chk("abort_col", bus.win_col, 0);
      chk("abort_last", bus.win_last, 0);
      @(negedge clk);
      reset = 0;
      repeat (5) @(negedge clk);
      chk("abort_no_done", done_cnt, 0);
      chk("abort_idle", busy, 0);
      pulse_start();
      wait_done(20000, ok);
      chk("p4_done", ok, 1);
      chk("p4_first_addr", addr_log.size() > 0 ? addr_log[0] : -1, 0);
      chk("p4_reads", addr_log.size(), 64);
      chk("p4_addr_order", addr_errs(), 0);
      chk("p4_windows", nwin, 7812);
      chk("p4_win_errs", win_errs, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
